// File: rtl/coder_lane_arbiter.sv
// coder_lane_arbiter: round-robin merge of coder byte lanes into one stream,
// bounded bursts per grant, frame-end detection once every lane has finished.
module coder_lane_arbiter #(
    parameter int NUM_LANES = 8,
    parameter int BURST_MAX = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_LANES-1:0]   in_valid,
    input  logic [8*NUM_LANES-1:0] in_byte,
    input  logic [NUM_LANES-1:0]   in_last,
    output logic [NUM_LANES-1:0]   in_ready,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [7:0]             out_bits_byte,
    output logic [7:0]             out_bits_idx,
    output logic                   out_bits_last,
    output logic                   busy
);

    localparam int IW = $clog2(NUM_LANES);
    localparam int CW = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;

    typedef enum logic {
        IDLE,
        SERVE
    } state_e;

    state_e                 state_q, state_d;
    logic [IW-1:0]          g_q, g_d;
    logic [IW-1:0]          rr_q, rr_d;
    logic [CW-1:0]          burst_q, burst_d;
    logic [NUM_LANES-1:0]   done_q, done_d;
    logic                   out_valid_q, out_valid_d;
    logic [7:0]             byte_q, byte_d;
    logic [7:0]             idx_q, idx_d;
    logic                   last_q, last_d;

    logic [NUM_LANES-1:0]   elig;
    logic [NUM_LANES-1:0]   lane_oh;
    logic [IW:0]            pos;
    logic [IW-1:0]          sel;
    logic                   found;
    logic [IW-1:0]          next_g;
    logic                   can_acc;
    logic                   accept;
    logic                   drain;
    logic                   all_done;
    logic [7:0]             cur_byte;

    // First eligible lane at or after rr_q, wrapping modulo NUM_LANES.
    always_comb begin
        elig  = in_valid & ~done_q;
        found = 1'b0;
        sel   = '0;
        pos   = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            pos = {1'b0, rr_q} + (IW+1)'(k);
            if (pos >= (IW+1)'(NUM_LANES)) begin
                pos = pos - (IW+1)'(NUM_LANES);
            end
            if (!found && elig[pos[IW-1:0]]) begin
                found = 1'b1;
                sel   = pos[IW-1:0];
            end
        end
    end

    always_comb begin
        lane_oh  = {{(NUM_LANES-1){1'b0}}, 1'b1} << g_q;
        next_g   = (g_q == IW'(NUM_LANES-1)) ? '0 : g_q + 1'b1;
        can_acc  = (state_q == SERVE) && !done_q[g_q]
                   && (!out_valid_q || out_ready);
        accept   = can_acc && in_valid[g_q];
        drain    = out_valid_q && out_ready;
        all_done = &(done_q | lane_oh);
        cur_byte = in_byte[{g_q, 3'b000} +: 8];
        in_ready = can_acc ? lane_oh : '0;
    end

    always_comb begin
        state_d     = state_q;
        g_d         = g_q;
        rr_d        = rr_q;
        burst_d     = burst_q;
        done_d      = done_q;
        out_valid_d = out_valid_q;
        byte_d      = byte_q;
        idx_d       = idx_q;
        last_d      = last_q;

        if (drain && !accept) begin
            out_valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (found) begin
                    g_d     = sel;
                    burst_d = '0;
                    state_d = SERVE;
                end
            end
            SERVE: begin
                if (accept) begin
                    out_valid_d = 1'b1;
                    byte_d      = cur_byte;
                    idx_d       = 8'(g_q);
                    last_d      = in_last[g_q] && all_done;
                    if (in_last[g_q]) begin
                        done_d = done_q | lane_oh;
                    end
                    if (in_last[g_q] || burst_q == CW'(BURST_MAX-1)) begin
                        state_d = IDLE;
                        rr_d    = next_g;
                    end else begin
                        burst_d = burst_q + 1'b1;
                    end
                end else if (can_acc) begin
                    // Lane went quiet while it could have sent: give up the grant.
                    state_d = IDLE;
                    rr_d    = next_g;
                end
            end
            default: state_d = IDLE;
        endcase

        if (drain && last_q) begin
            done_d = '0;
            rr_d   = '0;
        end
    end

    // rst_n is active-high here.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q     <= IDLE;
            g_q         <= '0;
            rr_q        <= '0;
            burst_q     <= '0;
            done_q      <= '0;
            out_valid_q <= 1'b0;
            byte_q      <= '0;
            idx_q       <= '0;
            last_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            g_q         <= g_d;
            rr_q        <= rr_d;
            burst_q     <= burst_d;
            done_q      <= done_d;
            out_valid_q <= out_valid_d;
            byte_q      <= byte_d;
            idx_q       <= idx_d;
            last_q      <= last_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_bits_byte = byte_q;
    assign out_bits_idx  = idx_q;
    assign out_bits_last = last_q;
    assign busy          = (state_q != IDLE) || out_valid_q;

endmodule

// File: tb/tb_coder_lane_arbiter.sv
// tb_coder_lane_arbiter: directed lane scenarios checked every cycle against
// a queue-level arbitration model, plus literal beat sequences per scenario.
module tb_coder_lane_arbiter;

    localparam int N  = 8;
    localparam int BM = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   in_valid = '0;
    logic [8*N-1:0] in_byte = '0;
    logic [N-1:0]   in_last = '0;
    logic [N-1:0]   in_ready;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [7:0]     out_bits_byte;
    logic [7:0]     out_bits_idx;
    logic           out_bits_last;
    logic           busy;

    always #5 clk = ~clk;

    coder_lane_arbiter #(.NUM_LANES(N), .BURST_MAX(BM)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_byte(in_byte),
        .in_last(in_last),
        .in_ready(in_ready),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_bits_byte(out_bits_byte),
        .out_bits_idx(out_bits_idx),
        .out_bits_last(out_bits_last),
        .busy(busy)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    // Per-lane byte queues: tl written by stimulus, hd advanced by the model.
    logic [8:0]   mem [N][64];
    int           hd [N];
    int           tl [N];
    logic [N-1:0] en;

    task automatic push(input int l, input int b, input bit last);
        mem[l][tl[l]] = {last, 8'(b)};
        tl[l]++;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            logic have;
            have = hd[i] < tl[i];
            in_valid[i]     = en[i] && have;
            in_byte[8*i+:8] = have ? mem[i][hd[i]][7:0] : 8'h00;
            in_last[i]      = have && mem[i][hd[i]][8];
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        drive();
    endtask

    // Model: m_grant = lane being served, -1 while arbitrating.
    int           m_grant;
    int           m_rr;
    int           m_taken;
    logic [N-1:0] m_done;
    bit           m_ov;
    logic [7:0]   m_byte;
    logic [7:0]   m_idx;
    bit           m_last;
    int           ml;
    bit           mok, macc, mdrn, mfin;

    initial for (int i = 0; i < N; i++) hd[i] = 0;

    always @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            m_grant = -1;
            m_rr    = 0;
            m_taken = 0;
            m_done  = '0;
            m_ov    = 0;
            m_byte  = 0;
            m_idx   = 0;
            m_last  = 0;
        end else begin
            mdrn = m_ov && out_ready;
            mfin = mdrn && m_last;
            mok  = m_grant >= 0 && !m_done[m_grant] && (!m_ov || out_ready);
            macc = mok && in_valid[m_grant];
            if (m_grant < 0) begin
                for (int k = 0; k < N; k++) begin
                    ml = (m_rr + k) % N;
                    if (m_grant < 0 && in_valid[ml] && !m_done[ml]) begin
                        m_grant = ml;
                        m_taken = 0;
                    end
                end
            end else if (macc) begin
                ml     = m_grant;
                m_ov   = 1;
                m_byte = in_byte[8*ml+:8];
                m_idx  = 8'(ml);
                m_last = in_last[ml] && ($countones(m_done) == N-1);
                if (in_last[ml]) m_done[ml] = 1'b1;
                m_taken++;
                hd[ml]++;
                if (in_last[ml] || m_taken == BM) begin
                    m_grant = -1;
                    m_rr    = (ml + 1) % N;
                end
            end else if (mok) begin
                m_rr    = (m_grant + 1) % N;
                m_grant = -1;
            end
            if (mdrn && !macc) m_ov = 0;
            if (mfin) begin
                m_done = '0;
                m_rr   = 0;
            end
        end
    end

    logic [16:0]  dut_b [128];
    int           dut_t [128];
    int           nb = 0;
    int           cyc_n = 0;
    logic [N-1:0] exp_ready;

    always @(negedge clk) begin
        cyc_n++;
        if (rst_n) begin
            chk("rst_in_ready", in_ready, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_byte", out_bits_byte, 0);
            chk("rst_idx", out_bits_idx, 0);
            chk("rst_last", out_bits_last, 0);
        end else begin
            exp_ready = '0;
            if (m_grant >= 0 && !m_done[m_grant] && (!m_ov || out_ready))
                exp_ready = N'(1) << m_grant;
            chk("in_ready", in_ready, exp_ready);
            chk("out_valid", out_valid, m_ov);
            chk("busy", busy, (m_grant >= 0) || m_ov);
            if (m_ov) begin
                chk("out_byte", out_bits_byte, m_byte);
                chk("out_idx", out_bits_idx, m_idx);
                chk("out_last", out_bits_last, m_last);
            end
            if (out_valid && out_ready && nb < 128) begin
                dut_b[nb] = {out_bits_last, out_bits_idx, out_bits_byte};
                dut_t[nb] = cyc_n;
                nb++;
            end
        end
    end

    logic [16:0] ex [32];
    int          ne = 0;
    int          base = 0;

    task automatic e(input bit last, input int idx, input int b);
        ex[ne] = {last, 8'(idx), 8'(b)};
        ne++;
    endtask

    task automatic run_beats(input string nm, input int n, input bit tog);
        int c;
        c = 0;
        while (nb - base < n && c < 400) begin
            if (tog) out_ready = ~out_ready;
            cyc();
            c++;
        end
        out_ready = 1'b1;
        repeat (4) cyc();
        chk($sformatf("%s_count", nm), nb - base, n);
    endtask

    task automatic expect_seq(input string nm);
        for (int i = 0; i < ne; i++)
            chk($sformatf("%s_beat%0d", nm, i), dut_b[base+i], ex[i]);
        ne = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        en    = '1;
        for (int i = 0; i < N; i++) tl[i] = 0;
        #1 rst_n = 1'b1;
        repeat (2) cyc();
        chk("reset_out_valid", out_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_in_ready", in_ready, 0);
        rst_n = 1'b0;
        cyc();

        // All lanes one byte each.
        base = nb;
        for (int i = 0; i < N; i++) begin
            push(i, 8'h10 + i, 1);
            e(i == 7, i, 8'h10 + i);
        end
        drive();
        run_beats("all1", 8, 0);
        expect_seq("all1");
        for (int i = 1; i < 8; i++)
            chk("all1_gap", dut_t[base+i] - dut_t[base+i-1], 2);

        // Lane 3 ten bytes, others single.
        base = nb;
        for (int i = 0; i < N; i++)
            if (i != 3) push(i, 8'h20 + i, 1);
        for (int k = 0; k < 10; k++) push(3, 8'h30 + k, k == 9);
        for (int i = 0; i < 3; i++) e(0, i, 8'h20 + i);
        for (int k = 0; k < 4; k++) e(0, 3, 8'h30 + k);
        for (int i = 4; i < 8; i++) e(0, i, 8'h20 + i);
        for (int k = 4; k < 10; k++) e(k == 9, 3, 8'h30 + k);
        drive();
        run_beats("burst", 17, 0);
        expect_seq("burst");
        chk("burst_gap_a", dut_t[base+12] - dut_t[base+11], 1);
        chk("burst_gap_b", dut_t[base+15] - dut_t[base+14], 2);
        chk("burst_gap_c", dut_t[base+16] - dut_t[base+15], 1);

        // Lanes 1 and 2 continuously valid.
        base = nb;
        for (int k = 0; k < 8; k++) begin
            push(1, 8'h40 + k, k == 7);
            push(2, 8'h50 + k, k == 7);
        end
        push(0, 8'h60, 1);
        for (int i = 3; i < 8; i++) push(i, 8'h60 + i, 1);
        e(0, 0, 8'h60);
        for (int k = 0; k < 4; k++) e(0, 1, 8'h40 + k);
        for (int k = 0; k < 4; k++) e(0, 2, 8'h50 + k);
        for (int i = 3; i < 8; i++) e(0, i, 8'h60 + i);
        for (int k = 4; k < 8; k++) e(0, 1, 8'h40 + k);
        for (int k = 4; k < 8; k++) e(k == 7, 2, 8'h50 + k);
        drive();
        run_beats("alt", 22, 0);
        expect_seq("alt");

        // out_ready toggling during bursts.
        base = nb;
        for (int k = 0; k < 6; k++) push(0, 8'hA0 + k, k == 5);
        for (int i = 1; i < 8; i++) push(i, 8'h70 + i, 1);
        for (int k = 0; k < 4; k++) e(0, 0, 8'hA0 + k);
        for (int i = 1; i < 8; i++) e(0, i, 8'h70 + i);
        e(0, 0, 8'hA4);
        e(1, 0, 8'hA5);
        drive();
        run_beats("tog", 13, 1);
        expect_seq("tog");

        // Reset while a byte is held under back-pressure.
        base = nb;
        push(0, 8'h80, 1);
        push(1, 8'h81, 1);
        for (int k = 0; k < 6; k++) push(2, 8'h90 + k, k == 5);
        e(0, 0, 8'h80);
        e(0, 1, 8'h81);
        drive();
        begin
            int c;
            c = 0;
            while (nb - base < 2 && c < 100) begin
                cyc();
                c++;
            end
        end
        out_ready = 1'b0;
        repeat (6) cyc();
        expect_seq("pre_rst");
        chk("held_valid", out_valid, 1);
        chk("held_byte", out_bits_byte, 8'h90);
        #2 rst_n = 1'b1;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_byte", out_bits_byte, 0);
        chk("mid_rst_idx", out_bits_idx, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", in_ready, 0);
        for (int i = 0; i < N; i++) tl[i] = hd[i];
        drive();
        out_ready = 1'b1;
        repeat (2) cyc();
        rst_n = 1'b0;
        cyc();
        base = nb;
        for (int i = 0; i < N; i++) begin
            push(i, 8'hC0 + i, 1);
            e(i == 7, i, 8'hC0 + i);
        end
        drive();
        run_beats("post_rst", 8, 0);
        expect_seq("post_rst");

        // Lane 5 finishes early, then re-asserts valid.
        base = nb;
        push(5, 8'hD5, 1);
        push(5, 8'hE5, 1);
        for (int i = 0; i < N; i++)
            if (i != 5) push(i, 8'hD0 + i, 1);
        en = 8'b0010_0000;
        drive();
        repeat (5) cyc();
        en = '1;
        drive();
        e(0, 5, 8'hD5);
        e(0, 6, 8'hD6);
        e(0, 7, 8'hD7);
        for (int i = 0; i < 5; i++) e(i == 4, i, 8'hD0 + i);
        e(0, 5, 8'hE5);
        run_beats("skip", 9, 0);
        expect_seq("skip");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule

// File: doc/coder_lane_arbiter.md
CODER_LANE_ARBITER -- requirements
Module: coder_lane_arbiter

Interface
REQ-001 Parameter NUM_LANES, default 8, number of coder byte lanes merged (2..8).
REQ-002 Parameter BURST_MAX, default 4, max bytes taken from one lane per grant (1..16).
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  NUM_LANES  per-lane byte valid.
REQ-006 in_byte  input  8*NUM_LANES  per-lane byte; lane i at bits [8i+7:8i].
REQ-007 in_last  input  NUM_LANES  per-lane final-byte marker.
REQ-008 in_ready  output  NUM_LANES  per-lane accept.
REQ-009 out_valid  output  1  merged stream valid.
REQ-010 out_ready  input  1  merged stream accept.
REQ-011 out_bits_byte  output  8  merged byte.
REQ-012 out_bits_idx  output  8  source lane number, zero-extended.
REQ-013 out_bits_last  output  1  final byte of the whole frame (all lanes finished).
REQ-014 busy  output  1  high when state is not IDLE or out_valid is high.

Function
REQ-015 The block SHALL be a 2-state FSM: IDLE (arbitrate) and SERVE (grant lane g).
REQ-016 Lane i is eligible when in_valid[i]=1 and done[i]=0; done[i] is set when in_last[i] is accepted.
REQ-017 IDLE: first eligible lane searched from rr_ptr upward, modulo NUM_LANES, is latched into g, burst_cnt<=0, go to SERVE next cycle; no eligible lane -> stay IDLE.
REQ-018 in_ready[i] = (state==SERVE) && (i==g) && !done[i] && (!out_valid || out_ready); all other bits 0.
REQ-019 Accept (in_valid[g] && in_ready[g]) loads the output register next edge: out_bits_byte<=in_byte[g], out_bits_idx<=g, out_valid<=1; latency 1 cycle.
REQ-020 out_valid SHALL hold with stable payload until out_ready; out_valid with no new accept and out_ready=1 clears it.
REQ-021 Accept and output drain in the same cycle SHALL be allowed (full throughput, one byte per clock).
REQ-022 SERVE release to IDLE on: accept with in_last[g]; accept with burst_cnt==BURST_MAX-1; or in_valid[g]=0 for a cycle while in_ready would be 1.
REQ-023 On release rr_ptr <= (g+1) mod NUM_LANES; otherwise burst_cnt increments per accept.
REQ-024 Re-arbitration costs exactly one IDLE cycle between grants.
REQ-025 out_bits_last SHALL be set on an accepted byte with in_last[g]=1 when all other lanes already have done=1.
REQ-026 When the out_bits_last beat is consumed (out_valid && out_ready && out_bits_last) all done bits and rr_ptr SHALL clear to 0 (next frame).
REQ-027 Lanes with done=1 SHALL be skipped and never granted; their in_valid is ignored until frame clear.
REQ-028 Back-pressure (out_ready=0) SHALL not change state, g, burst_cnt or rr_ptr.

Reset
REQ-029 rst_n=1 SHALL immediately force: state IDLE, g=0, rr_ptr=0, burst_cnt=0, done=0, out_valid=0, out_bits_byte=0, out_bits_idx=0, out_bits_last=0, in_ready=0, busy=0.
REQ-030 Reset mid-transfer SHALL discard the held output byte and all frame progress; no partial beat emitted after release.

Verification
REQ-031 Lanes 0..7 each present 1 byte (0x10+i, last=1) at once, out_ready=1 -> output order idx 0..7, 2 cycles per byte, out_bits_last only on idx 7.
REQ-032 Lane 3 only valid, 10 bytes, BURST_MAX=4, others done -> bursts 4,4,2 from idx 3 separated by one IDLE cycle each, last on 10th byte.
REQ-033 Lanes 1 and 2 continuously valid, 8 bytes each -> grants alternate 1,2,1,2 in bursts of 4; no lane starved.
REQ-034 out_ready toggled 0/1 every cycle during a burst -> payload stable while out_valid && !out_ready; byte sequence complete, no duplicates/losses.
REQ-035 rst_n pulsed while out_valid=1 mid-burst -> all outputs 0 immediately; after release, arbitration restarts at lane 0.
REQ-036 Lane 5 sends last while lanes 0..4,6,7 not done, then re-asserts valid -> lane 5 never re-granted until frame clear after out_bits_last.
